// File: rtl/llc_mesi_engine_pkg.sv
// Shared types for the last-level MESI cache engine: trace command codes,
// line states, bus operations, snoop results and the modelled snoop reply.
package llc_mesi_engine_pkg;

  typedef enum logic [3:0] {
    CMD_READ         = 4'd0,
    CMD_WRITE        = 4'd1,
    CMD_L1_READ      = 4'd2,
    CMD_SNOOP_INVAL  = 4'd3,
    CMD_SNOOPED_RD   = 4'd4,
    CMD_SNOOP_WR     = 4'd5,
    CMD_SNOOP_RDWITM = 4'd6,
    CMD_CLR          = 4'd8,
    CMD_PRINT        = 4'd9
  } cmd_e;

  typedef enum logic [1:0] {MESI_I, MESI_S, MESI_E, MESI_M} mesi_e;

  typedef enum logic [1:0] {BUS_READ, BUS_WRITE, BUS_INVALIDATE, BUS_RWIM} busop_e;

  typedef enum logic [1:0] {SNP_HIT = 2'd0, SNP_HITM = 2'd1, SNP_NOHIT = 2'd2} snoop_e;

  typedef enum logic [2:0] {ST_SWEEP, ST_IDLE, ST_LOOKUP, ST_WB, ST_ACT} state_e;

  // What the other caches answer when we put one of our own reads on the bus.
  function automatic snoop_e snoop_model(input logic [1:0] lsb);
    case (lsb)
      2'd0:    return SNP_HIT;
      2'd1:    return SNP_HITM;
      default: return SNP_NOHIT;
    endcase
  endfunction

endpackage

// File: rtl/llc_mesi_engine_plru_tree.sv
// Tree pseudo-LRU for one set: each node bit points toward the colder half
// (0 = lower half). Gives the victim way and the bits after touching a way.
module plru_tree #(
  parameter int WAYS = 16,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic [WAYS-2:0]  bits_i,
  input  logic [WAY_W-1:0] touch_i,
  output logic [WAYS-2:0]  bits_o,
  output logic [WAY_W-1:0] victim_o
);

  logic [WAY_W-1:0] vnode;
  logic [WAY_W-1:0] tnode;

  always_comb begin
    bits_o   = bits_i;
    victim_o = '0;
    vnode    = '0;
    tnode    = '0;
    for (int l = 0; l < WAY_W; l++) begin
      victim_o[WAY_W-1-l] = bits_i[vnode];
      vnode = WAY_W'(2 * vnode + 1 + bits_i[vnode]);
      // Point each node on the touched path away from the touched way.
      bits_o[tnode] = ~touch_i[WAY_W-1-l];
      tnode = WAY_W'(2 * tnode + 1 + touch_i[WAY_W-1-l]);
    end
  end

endmodule

// File: rtl/llc_mesi_engine.sv
// Last-level cache controller: one trace command at a time through
// SWEEP/IDLE/LOOKUP/WB/ACT, holding tag, MESI and pseudo-LRU arrays per set.
module llc_mesi_engine
  import llc_mesi_engine_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 6,
  parameter int INDEX_W  = 14,
  parameter int WAYS     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic              busop_valid,
  output logic [1:0]        busop,
  output logic [ADDR_W-1:0] busop_addr,
  output logic              done_valid,
  output logic              done_hit,
  output logic [1:0]        snoop_rslt,
  output logic              cmd_err,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt,
  output logic [31:0]       rd_cnt,
  output logic [31:0]       wr_cnt
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int SETS  = 1 << INDEX_W;
  localparam int WAY_W = $clog2(WAYS);

  logic [TAG_W-1:0] tag_q  [SETS][WAYS];
  mesi_e            mesi_q [SETS][WAYS];
  logic [WAYS-2:0]  plru_q [SETS];

  state_e             state_q, state_d;
  logic [INDEX_W-1:0] sweep_q, sweep_d;
  logic               clr_pend_q, clr_pend_d;
  logic [3:0]         cmd_q, cmd_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               hit_q, hit_d;
  logic [WAY_W-1:0]   way_q, way_d;
  mesi_e              line_q, line_d;
  logic [TAG_W-1:0]   vtag_q, vtag_d;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   cur_tag;
  logic               hit_found, inv_found, is_access, is_snoop;
  logic [WAY_W-1:0]   hit_way, inv_way, plru_victim;
  logic [WAYS-2:0]    plru_upd;
  logic               sweep_we, st_we, tag_we, plru_we;
  mesi_e              st_new;
  logic               cnt_clr, cnt_rd, cnt_wr, cnt_hit, cnt_miss;

  assign idx       = addr_q[OFFSET_W +: INDEX_W];
  assign cur_tag   = addr_q[ADDR_W-1 -: TAG_W];
  assign is_access = (cmd_q == CMD_READ) || (cmd_q == CMD_WRITE) || (cmd_q == CMD_L1_READ);
  assign is_snoop  = (cmd_q >= CMD_SNOOP_INVAL) && (cmd_q <= CMD_SNOOP_RDWITM);

  plru_tree #(.WAYS(WAYS)) u_plru (
    .bits_i   (plru_q[idx]),
    .touch_i  (way_q),
    .bits_o   (plru_upd),
    .victim_o (plru_victim)
  );

  // Scan from the top so the lowest matching way wins.
  always_comb begin
    hit_found = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (mesi_q[idx][w] != MESI_I && tag_q[idx][w] == cur_tag) begin
        hit_found = 1'b1;
        hit_way   = WAY_W'(w);
      end
      if (mesi_q[idx][w] == MESI_I) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;  sweep_d = sweep_q;  clr_pend_d = clr_pend_q;
    cmd_d   = cmd_q;    addr_d  = addr_q;   hit_d      = hit_q;
    way_d   = way_q;    line_d  = line_q;   vtag_d     = vtag_q;
    cmd_ready = 1'b0;  busop_valid = 1'b0;  busop = '0;  busop_addr = '0;
    done_valid = 1'b0; done_hit = 1'b0;     snoop_rslt = '0;  cmd_err = 1'b0;
    sweep_we = 1'b0;   st_we = 1'b0;  st_new = MESI_I;  tag_we = 1'b0;  plru_we = 1'b0;
    cnt_clr = 1'b0;    cnt_rd = 1'b0; cnt_wr = 1'b0;    cnt_hit = 1'b0; cnt_miss = 1'b0;
    unique case (state_q)
      ST_SWEEP: begin
        sweep_we = 1'b1;
        sweep_d  = sweep_q + 1'b1;
        if (sweep_q == '1) begin
          state_d    = ST_IDLE;
          done_valid = clr_pend_q;
          clr_pend_d = 1'b0;
        end
      end
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cmd_d  = cmd;
          addr_d = cmd_addr;
          if (cmd == CMD_CLR) begin
            state_d    = ST_SWEEP;
            sweep_d    = '0;
            clr_pend_d = 1'b1;
            cnt_clr    = 1'b1;
          end else begin
            state_d = ST_LOOKUP;
          end
        end
      end
      ST_LOOKUP: begin
        hit_d   = hit_found && (is_access || is_snoop);
        way_d   = hit_found ? hit_way : (inv_found ? inv_way : plru_victim);
        line_d  = hit_found ? mesi_q[idx][hit_way] : MESI_I;
        vtag_d  = tag_q[idx][plru_victim];
        state_d = (is_access && !hit_found && !inv_found && mesi_q[idx][plru_victim] == MESI_M)
                  ? ST_WB : ST_ACT;
      end
      ST_WB: begin
        busop_valid = 1'b1;
        busop       = BUS_WRITE;
        busop_addr  = {vtag_q, idx, {OFFSET_W{1'b0}}};
        state_d     = ST_ACT;
      end
      ST_ACT: begin
        done_valid = 1'b1;
        done_hit   = hit_q;
        state_d    = ST_IDLE;
        if (is_access) begin
          cnt_hit  = hit_q;
          cnt_miss = !hit_q;
          plru_we  = 1'b1;
        end
        case (cmd_q)
          CMD_READ, CMD_L1_READ: begin
            cnt_rd = 1'b1;
            if (!hit_q) begin
              busop_valid = 1'b1;  busop = BUS_READ;  busop_addr = addr_q;
              st_we  = 1'b1;
              tag_we = 1'b1;
              st_new = (snoop_model(addr_q[1:0]) == SNP_NOHIT) ? MESI_E : MESI_S;
            end
          end
          CMD_WRITE: begin
            cnt_wr = 1'b1;
            st_we  = 1'b1;
            st_new = MESI_M;
            if (!hit_q) begin
              busop_valid = 1'b1;  busop = BUS_RWIM;  busop_addr = addr_q;
              tag_we = 1'b1;
            end else if (line_q == MESI_S) begin
              busop_valid = 1'b1;  busop = BUS_INVALIDATE;  busop_addr = addr_q;
            end
          end
          CMD_SNOOPED_RD, CMD_SNOOP_RDWITM: begin
            snoop_rslt = SNP_NOHIT;
            if (line_q != MESI_I) begin
              st_we      = 1'b1;
              st_new     = (cmd_q == CMD_SNOOPED_RD) ? MESI_S : MESI_I;
              snoop_rslt = SNP_HIT;
              if (line_q == MESI_M) begin
                snoop_rslt  = SNP_HITM;
                busop_valid = 1'b1;
                busop       = BUS_WRITE;
                busop_addr  = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
              end
            end
          end
          CMD_SNOOP_INVAL: begin
            snoop_rslt = SNP_NOHIT;
            if (line_q == MESI_S) begin
              snoop_rslt = SNP_HIT;
              st_we      = 1'b1;
              st_new     = MESI_I;
            end
          end
          CMD_SNOOP_WR: snoop_rslt = SNP_NOHIT;
          CMD_PRINT:    ;
          default:      cmd_err = 1'b1;
        endcase
      end
      default: state_d = ST_SWEEP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_SWEEP;  sweep_q <= '0;  clr_pend_q <= 1'b0;
      cmd_q   <= '0;        addr_q  <= '0;  hit_q      <= 1'b0;
      way_q   <= '0;        line_q  <= MESI_I;  vtag_q <= '0;
    end else begin
      state_q <= state_d;  sweep_q <= sweep_d;  clr_pend_q <= clr_pend_d;
      cmd_q   <= cmd_d;    addr_q  <= addr_d;   hit_q      <= hit_d;
      way_q   <= way_d;    line_q  <= line_d;   vtag_q     <= vtag_d;
    end
  end

  // NOTE: the arrays have no reset; SWEEP invalidates them one set per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (sweep_we) begin
        for (int w = 0; w < WAYS; w++) mesi_q[sweep_q][w] <= MESI_I;
        plru_q[sweep_q] <= '0;
      end
      if (st_we)   mesi_q[idx][way_q] <= st_new;
      if (tag_we)  tag_q[idx][way_q]  <= cur_tag;
      if (plru_we) plru_q[idx]        <= plru_upd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      hit_cnt <= '0;  miss_cnt <= '0;  rd_cnt <= '0;  wr_cnt <= '0;
    end else begin
      if (cnt_hit  && hit_cnt  != '1) hit_cnt  <= hit_cnt  + 32'd1;
      if (cnt_miss && miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
      if (cnt_rd   && rd_cnt   != '1) rd_cnt   <= rd_cnt   + 32'd1;
      if (cnt_wr   && wr_cnt   != '1) wr_cnt   <= wr_cnt   + 32'd1;
    end
  end

endmodule

// File: doc/llc_mesi_engine.md
Name: llc_mesi_engine

Overview:
- Parametrised last-level cache controller that replaces the trace bench's per-command print tasks with real sequential state.
- Accepts one trace command per handshake from the trace driver and holds tag/MESI/pseudo-LRU arrays.
- Emits bus operations and snoop responses.
- The snoop result that other caches return on our own reads is modelled from address[1:0]: 0 = HIT, 1 = HITM, 2 or 3 = NOHIT.

Parameters:
ADDR_W, 32, address width
OFFSET_W, 6, byte-select bits (64 B line)
INDEX_W, 14, set-index bits
WAYS, 16, associativity; power of two, at least 2; tag width = ADDR_W-INDEX_W-OFFSET_W

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  engine idle, command accepted on valid&&ready
cmd  in  4  trace code (package enum)
cmd_addr  in  ADDR_W  command address
busop_valid  out  1  one-cycle bus-operation pulse, no backpressure
busop  out  2  READ / WRITE / INVALIDATE / RWIM
busop_addr  out  ADDR_W  bus address
done_valid  out  1  one-cycle completion pulse
done_hit  out  1  lookup hit (valid with done)
snoop_rslt  out  2  our HIT/HITM/NOHIT for snooped commands (valid with done)
cmd_err  out  1  unsupported code (valid with done)
hit_cnt, miss_cnt, rd_cnt, wr_cnt  out  32 each  statistics, saturating

Behaviour:
- Reset sets every output to 0, then enters SWEEP. SWEEP runs 2^INDEX_W cycles: one set per cycle has all ways set to I and its PLRU bits cleared. cmd_ready is asserted the cycle after the last set is swept.
- FSM states: SWEEP, IDLE, LOOKUP, WB, ACT.
  - IDLE: cmd_ready=1; on accept, register cmd/addr, go to LOOKUP.
  - LOOKUP: compute hit way. Victim = lowest invalid way, else tree-PLRU victim. Go to WB if the op needs a dirty writeback, else ACT.
  - WB: busop WRITE at the line-aligned victim/line address, then ACT.
  - ACT: issue the fill/upgrade busop if any, update state and PLRU, pulse done, return to IDLE.
- Latency: done 2 cycles after accept without writeback, 3 cycles with writeback.
- PLRU is touched on a READ/WRITE/L1_READ hit and on a fill, never on snoops.
- READ / L1_READ:
  - Hit: no busop; state unchanged.
  - Miss: optional WB, then busop READ at cmd_addr. New state S if the modelled result is HIT or HITM, E if NOHIT.
  - Counts rd_cnt.
- WRITE:
  - M hit: no busop.
  - E hit: becomes M, no busop.
  - S hit: busop INVALIDATE, becomes M.
  - Miss: optional WB, then busop RWIM, line M.
  - Counts wr_cnt.
- SNOOPED_RD:
  - M: HITM, busop WRITE line-aligned, becomes S.
  - E or S: HIT, becomes S.
  - I: NOHIT.
- SNOOP_RDWITM:
  - M: HITM, busop WRITE, becomes I.
  - E or S: HIT, becomes I.
  - I: NOHIT.
- SNOOP_INVAL: S becomes I with HIT; otherwise NOHIT and no change.
- SNOOP_WR: NOHIT, no change.
- The snoop-writeback WRITE is issued in ACT; snooped commands never use WB.
- hit_cnt / miss_cnt count only READ, WRITE and L1_READ.
- CLR: enters SWEEP and clears the counters; done pulses on the SWEEP exit cycle.
- PRINT: done only, no change.
- Any other code: done with cmd_err=1, no change.
- rst in any state aborts the current command: no further busop or done, and the engine enters SWEEP.
- WB followed by fill always appears as two consecutive busop pulses.

Decomposition:
- mypkg holds:
  - command enum (0 READ, 1 WRITE, 2 L1_READ, 3 SNOOP_INVAL, 4 SNOOPED_RD, 5 SNOOP_WR, 6 SNOOP_RDWITM, 8 CLR, 9 PRINT)
  - MESI enum
  - busop enum
  - snoop enum (HIT=0, HITM=1, NOHIT=2)
  - the address-LSB snoop-model function
- One sub-module, plru_tree: WAYS-1 bits per set; inputs are current bits plus touched way; outputs are updated bits and victim way.

Test Plan:
1. Release reset -> cmd_ready 0 for 16384 cycles. Then READ 0x00000402 -> busop READ 0x00000402, done_hit 0, line E. Repeat the READ -> done_hit 1, no busop, hit_cnt 1, miss_cnt 1.
2. Continue from test 1: WRITE 0x00000402 -> no busop, done_hit 1, line M. SNOOPED_RD 0x00000402 -> snoop_rslt HITM, busop WRITE 0x00000400, line S. SNOOP_INVAL 0x00000402 -> HIT, line I.
3. READ 0x00000500 -> busop READ, line S (addr[1:0]=0 gives HIT). WRITE 0x00000500 -> busop INVALIDATE 0x00000500, line M.
4. WRITE tags 0..15 in set 0 (addr = t<<20), each giving busop RWIM. Then READ 0x01000000 -> busop WRITE 0x00000000, next cycle busop READ 0x01000000 (victim way 0), done 3 cycles after accept.
5. CLR -> cmd_ready low 16384 cycles, all counters 0. Re-READ 0x00000500 -> miss. Command code 7 -> done, cmd_err 1, no busop.
6. Assert rst in the WB cycle of test 4 -> no READ busop, no done; SWEEP restarts and cmd_ready stays low 16384 cycles.
